// File: rtl/keyboard_decoder.sv
// -----------------------------------------------------------------------------
// keyboard_decoder
//
// Turns the PS/2 set-2 scan-code byte stream into ASCII characters, queues
// them in a small FIFO and exposes them to the processor through two
// memory-mapped read registers.
//
// The decoder tracks F0 (break) and E0 (extended) prefixes and a shift flag.
// Make codes that have a translation push one character per byte, so
// typematic repeats each produce a character. Break codes never push a
// character.
//
// Processor registers:
//   DATA_ADDR   : reading pops the head character and returns it in
//                 bits [7:0]. An empty FIFO returns 0.
//   STATUS_ADDR : bit0 = non-empty, bit1 = full, bit2 = overflow,
//                 bits[12:8] = count. Reading it clears overflow.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   rx_data    in   [7:0]  scan-code byte from the PS/2 receiver
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   proc_addr  in   [31:0] processor read address
//   proc_re    in   processor read strobe, one cycle per access
//   proc_rdata out  [31:0] registered read data, held while proc_re=0
//   key_ready  out  high while the FIFO holds at least one character
//   overflow   out  sticky flag: a character was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module keyboard_decoder #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] DATA_ADDR   = 32'h2010,
  parameter logic [31:0] STATUS_ADDR = 32'h200C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] proc_addr,
  input  logic        proc_re,
  output logic [31:0] proc_rdata,
  output logic        key_ready,
  output logic        overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  // Normal make codes. Letters are stored lower case and shifted to upper
  // case by subtracting 0x20. Digits and control keys ignore shift.
  // Result is {valid, ascii}.
  function automatic logic [8:0] mapNormal(input logic [7:0] code,
                                           input logic       shift);
    logic [7:0] letter;
    logic [8:0] result;
    letter = 8'h00;
    result = 9'h000;
    case (code)
      8'h1C: letter = 8'h61; // a
      8'h32: letter = 8'h62; // b
      8'h21: letter = 8'h63; // c
      8'h23: letter = 8'h64; // d
      8'h24: letter = 8'h65; // e
      8'h2B: letter = 8'h66; // f
      8'h34: letter = 8'h67; // g
      8'h33: letter = 8'h68; // h
      8'h43: letter = 8'h69; // i
      8'h3B: letter = 8'h6A; // j
      8'h42: letter = 8'h6B; // k
      8'h4B: letter = 8'h6C; // l
      8'h3A: letter = 8'h6D; // m
      8'h31: letter = 8'h6E; // n
      8'h44: letter = 8'h6F; // o
      8'h4D: letter = 8'h70; // p
      8'h15: letter = 8'h71; // q
      8'h2D: letter = 8'h72; // r
      8'h1B: letter = 8'h73; // s
      8'h2C: letter = 8'h74; // t
      8'h3C: letter = 8'h75; // u
      8'h2A: letter = 8'h76; // v
      8'h1D: letter = 8'h77; // w
      8'h22: letter = 8'h78; // x
      8'h35: letter = 8'h79; // y
      8'h1A: letter = 8'h7A; // z
      default: letter = 8'h00;
    endcase

    if (letter != 8'h00) begin
      result = {1'b1, shift ? (letter - 8'h20) : letter};
    end else begin
      case (code)
        8'h45: result = {1'b1, 8'h30};
        8'h16: result = {1'b1, 8'h31};
        8'h1E: result = {1'b1, 8'h32};
        8'h26: result = {1'b1, 8'h33};
        8'h25: result = {1'b1, 8'h34};
        8'h2E: result = {1'b1, 8'h35};
        8'h36: result = {1'b1, 8'h36};
        8'h3D: result = {1'b1, 8'h37};
        8'h3E: result = {1'b1, 8'h38};
        8'h46: result = {1'b1, 8'h39};
        8'h29: result = {1'b1, 8'h20}; // space
        8'h5A: result = {1'b1, 8'h0D}; // enter
        8'h66: result = {1'b1, 8'h08}; // backspace
        8'h76: result = {1'b1, 8'h1B}; // escape
        default: result = 9'h000;
      endcase
    end
    return result;
  endfunction

  // Extended (E0-prefixed) make codes: arrow keys map to DC1..DC4.
  function automatic logic [8:0] mapExtended(input logic [7:0] code);
    logic [8:0] result;
    result = 9'h000;
    case (code)
      8'h6B: result = {1'b1, 8'h11}; // left
      8'h74: result = {1'b1, 8'h12}; // right
      8'h75: result = {1'b1, 8'h13}; // up
      8'h72: result = {1'b1, 8'h14}; // down
      default: result = 9'h000;
    endcase
    return result;
  endfunction

  state_e       state_q, state_d;
  logic         shift_q, shift_d;
  logic [7:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic         overflow_q, overflow_d;
  logic [31:0]  rdata_q, rdata_d;

  logic         charValid;
  logic [7:0]   charData;
  logic [8:0]   normMap;
  logic [8:0]   extMap;
  logic         isShiftCode;
  logic         fifoEmpty;
  logic         fifoFull;
  logic         dataSel;
  logic         statusSel;
  logic         pop;
  logic         push;
  logic         dropped;
  logic [4:0]   count5;
  logic [31:0]  statusWord;

  // Decoder: everything, including the prefix state and shift, moves only on
  // bytes from the receiver. Every byte returns to IDLE unless it is a prefix
  // that extends the current sequence; a stray prefix inside a break
  // sequence is simply consumed as the (ignored) break code.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    charValid   = 1'b0;
    charData    = 8'h00;
    normMap     = mapNormal(rx_data, shift_q);
    extMap      = mapExtended(rx_data);
    isShiftCode = (rx_data == 8'h12) || (rx_data == 8'h59);

    if (rx_valid) begin
      state_d = IDLE;
      case (state_q)
        IDLE: begin
          if (rx_data == 8'hF0) begin
            state_d = BRK;
          end else if (rx_data == 8'hE0) begin
            state_d = EXT;
          end else if (isShiftCode) begin
            shift_d = 1'b1;
          end else begin
            charValid = normMap[8];
            charData  = normMap[7:0];
          end
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            charValid = extMap[8];
            charData  = extMap[7:0];
          end
        end
        BRK: begin
          if (isShiftCode) begin
            shift_d = 1'b0;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  // FIFO control and register reads. A pop frees a slot in the same cycle,
  // so a push into a full FIFO succeeds when a data read pops alongside it.
  // A data read of an empty FIFO never pops, so a simultaneous push lands
  // and the read returns zero.
  always_comb begin
    fifoEmpty  = (count_q == '0);
    fifoFull   = (count_q == CW'(FIFO_DEPTH));
    dataSel    = proc_re && (proc_addr == DATA_ADDR);
    statusSel  = proc_re && (proc_addr == STATUS_ADDR) && !dataSel;
    pop        = dataSel && !fifoEmpty;
    push       = charValid && (!fifoFull || pop);
    dropped    = charValid && fifoFull && !pop;
    count5     = 5'(count_q);
    statusWord = {19'h0, count5, 5'h0, overflow_q, fifoFull, !fifoEmpty};

    wrPtr_d = push ? (wrPtr_q + PW'(1)) : wrPtr_q;
    rdPtr_d = pop  ? (rdPtr_q + PW'(1)) : rdPtr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // A drop in the same cycle as a status read leaves the flag set.
    overflow_d = overflow_q;
    if (dropped) begin
      overflow_d = 1'b1;
    end else if (statusSel) begin
      overflow_d = 1'b0;
    end

    rdata_d = rdata_q;
    if (dataSel) begin
      rdata_d = fifoEmpty ? 32'h0 : {24'h0, mem_q[rdPtr_q]};
    end else if (statusSel) begin
      rdata_d = statusWord;
    end else if (proc_re) begin
      rdata_d = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wrPtr_q] <= charData;
    end
  end

  assign proc_rdata = rdata_q;
  assign key_ready  = (count_q != '0);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// -----------------------------------------------------------------------------
// tb_keyboard_decoder
//
// Directed bench for keyboard_decoder. Inputs change on the falling edge and
// are held for one full cycle; outputs are sampled on the following falling
// edge, after the registered update.
// -----------------------------------------------------------------------------
module tb_keyboard_decoder;

  localparam logic [31:0] DATA   = 32'h2010;
  localparam logic [31:0] STATUS = 32'h200C;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] proc_addr;
  logic        proc_re;
  logic [31:0] proc_rdata;
  logic        key_ready;
  logic        overflow;

  int checks;
  int errors;

  keyboard_decoder #(
    .FIFO_DEPTH (8),
    .DATA_ADDR  (DATA),
    .STATUS_ADDR(STATUS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .proc_addr (proc_addr),
    .proc_re   (proc_re),
    .proc_rdata(proc_rdata),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus: drive at a falling edge, release at the next.
  task automatic applyStimulus(input logic rxv, input logic [7:0] rxd,
                               input logic re, input logic [31:0] addr);
    @(negedge clk);
    rx_valid  = rxv;
    rx_data   = rxd;
    proc_re   = re;
    proc_addr = addr;
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    proc_re   = 1'b0;
    proc_addr = 32'h0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp);
    applyStimulus(1'b0, 8'h00, 1'b1, addr);
    checkOutput(tag, proc_rdata, exp);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    proc_re   = 1'b0;
    proc_addr = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", proc_rdata, 32'h0);
    checkOutput("reset_key_ready", {31'h0, key_ready}, 32'h0);
    checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
    reset = 1'b0;

    // Single make code
    sendByte(8'h1C);
    checkOutput("a_key_ready", {31'h0, key_ready}, 32'h1);
    readCheck("a_data", DATA, 32'h61);
    checkOutput("a_key_ready_after", {31'h0, key_ready}, 32'h0);

    // Shift make, letter, letter break, shift break, letter
    sendByte(8'h12); sendByte(8'h1C); sendByte(8'hF0); sendByte(8'h1C);
    sendByte(8'hF0); sendByte(8'h12); sendByte(8'h1C);
    readCheck("shift_status", STATUS, 32'h0201);
    readCheck("shift_upper", DATA, 32'h41);
    readCheck("shift_lower", DATA, 32'h61);
    readCheck("shift_empty", STATUS, 32'h0000);

    // Extended make then extended break
    sendByte(8'hE0); sendByte(8'h75); sendByte(8'hE0); sendByte(8'hF0);
    sendByte(8'h75);
    readCheck("ext_status", STATUS, 32'h0101);
    readCheck("ext_up", DATA, 32'h13);

    // Digit, space, extended left, unmapped, digit with shift held
    sendByte(8'h45); sendByte(8'h29); sendByte(8'hE0); sendByte(8'h6B);
    sendByte(8'h77); sendByte(8'h12); sendByte(8'h1E); sendByte(8'hF0);
    sendByte(8'h12);
    readCheck("mix_status", STATUS, 32'h0401);
    readCheck("mix_zero", DATA, 32'h30);
    readCheck("mix_space", DATA, 32'h20);
    readCheck("mix_left", DATA, 32'h11);
    readCheck("mix_two_shift", DATA, 32'h32);

    // Nine typematic makes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) sendByte(8'h16);
    checkOutput("ovf_flag", {31'h0, overflow}, 32'h1);
    readCheck("ovf_status", STATUS, 32'h0807);
    checkOutput("ovf_cleared", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 8; i++) readCheck("ovf_drain", DATA, 32'h31);
    readCheck("ovf_empty", STATUS, 32'h0000);

    // Data read while empty
    readCheck("empty_data", DATA, 32'h0);
    readCheck("empty_status", STATUS, 32'h0000);

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 8; i++) sendByte(8'h1C);
    applyStimulus(1'b1, 8'h32, 1'b1, DATA);
    checkOutput("fullpp_data", proc_rdata, 32'h61);
    checkOutput("fullpp_ovf", {31'h0, overflow}, 32'h0);
    readCheck("fullpp_status", STATUS, 32'h0803);
    for (int i = 0; i < 7; i++) readCheck("fullpp_drain", DATA, 32'h61);
    readCheck("fullpp_last", DATA, 32'h62);
    readCheck("fullpp_empty", STATUS, 32'h0000);

    // Empty FIFO: push and pop in the same cycle
    applyStimulus(1'b1, 8'h1C, 1'b1, DATA);
    checkOutput("emptypp_data", proc_rdata, 32'h0);
    readCheck("emptypp_status", STATUS, 32'h0101);
    readCheck("emptypp_char", DATA, 32'h61);

    // Overflow set in the same cycle as a status read
    for (int i = 0; i < 8; i++) sendByte(8'h1C);
    applyStimulus(1'b1, 8'h1C, 1'b1, STATUS);
    checkOutput("setwins_status", proc_rdata, 32'h0803);
    checkOutput("setwins_ovf", {31'h0, overflow}, 32'h1);
    readCheck("setwins_status2", STATUS, 32'h0807);
    applyStimulus(1'b0, 8'h00, 1'b0, STATUS);
    checkOutput("hold_rdata", proc_rdata, 32'h0807);
    for (int i = 0; i < 8; i++) readCheck("setwins_drain", DATA, 32'h61);
    readCheck("other_addr", 32'h0000_1234, 32'h0);

    // Reset aborts a pending break and beats simultaneous activity
    sendByte(8'hF0);
    reset = 1'b1;
    applyStimulus(1'b1, 8'h1C, 1'b1, STATUS);
    reset = 1'b0;
    checkOutput("rst_prio_rdata", proc_rdata, 32'h0);
    checkOutput("rst_prio_ready", {31'h0, key_ready}, 32'h0);
    sendByte(8'h1C);
    checkOutput("rst_abort_ready", {31'h0, key_ready}, 32'h1);
    readCheck("rst_abort_status", STATUS, 32'h0101);
    readCheck("rst_abort_char", DATA, 32'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
